// File: rtl/vcve2_vrf_agu.sv
// VRF address generation unit: turns vs1/vs2/vd indices into byte addresses and walks them per bus word.
// Build option: define VCVE2_AGU_WRAP_CHECK_EN to raise a sticky err_o when a pointer wraps past the last VRF word.
module vcve2_vrf_agu #(
    parameter int unsigned VLEN          = 128,
    parameter int unsigned PIPE_WIDTH    = 32,
    parameter int unsigned AddrWidth     = 5,
    parameter logic [31:0] VRF_BASE_ADDR = 32'h0001_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [AddrWidth-1:0] vs1_i,
    input  logic [AddrWidth-1:0] vs2_i,
    input  logic [AddrWidth-1:0] vd_i,
    input  logic                 get_rs1_i,
    input  logic                 get_rs2_i,
    input  logic                 get_rd_noincr_i,
    input  logic                 get_rd_i,
    output logic                 ready_o,
    output logic [31:0]          addr_o,
    output logic                 err_o
);

    localparam int unsigned REG_BYTES = VLEN / 8;
    localparam int unsigned REG_SHIFT = $clog2(REG_BYTES);
    localparam int unsigned OFFS_W    = AddrWidth + REG_SHIFT;
    localparam int unsigned STEP      = PIPE_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        READY = 2'd2
    } state_e;

    state_e               r_state;
    logic                 r_ready;
    logic [AddrWidth-1:0] r_vs1;
    logic [AddrWidth-1:0] r_vs2;
    logic [AddrWidth-1:0] r_vd;
    logic [OFFS_W-1:0]    r_ptr_rs1;
    logic [OFFS_W-1:0]    r_ptr_rs2;
    logic [OFFS_W-1:0]    r_ptr_rd;

    logic                 w_active;
    logic                 w_sel_rs1;
    logic                 w_sel_rs2;
    logic                 w_sel_rdn;
    logic                 w_sel_rd;
    logic [OFFS_W-1:0]    w_sel_ptr;
    logic [OFFS_W-1:0]    w_ptr_next;

    // Get arbitration: only in READY and never in a load cycle; rs1 > rs2 > rd_noincr > rd.
    assign w_active  = (r_state == READY) && !load_i;
    assign w_sel_rs1 = w_active && get_rs1_i;
    assign w_sel_rs2 = w_active && !get_rs1_i && get_rs2_i;
    assign w_sel_rdn = w_active && !get_rs1_i && !get_rs2_i && get_rd_noincr_i;
    assign w_sel_rd  = w_active && !get_rs1_i && !get_rs2_i && !get_rd_noincr_i && get_rd_i;

    always_comb begin
        w_sel_ptr = '0;
        if (w_sel_rs1) begin
            w_sel_ptr = r_ptr_rs1;
        end else if (w_sel_rs2) begin
            w_sel_ptr = r_ptr_rs2;
        end else if (w_sel_rdn || w_sel_rd) begin
            w_sel_ptr = r_ptr_rd;
        end
    end

    // Offset width equals log2 of the VRF size, so the natural carry-out is the modulo wrap.
    assign w_ptr_next = w_sel_ptr + OFFS_W'(STEP);

    // Base is aligned to the VRF size, so OR-ing the offset is an add; idle selection is zero.
    assign addr_o  = VRF_BASE_ADDR | 32'(w_sel_ptr);
    assign ready_o = r_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_ready   <= 1'b0;
            r_vs1     <= '0;
            r_vs2     <= '0;
            r_vd      <= '0;
            r_ptr_rs1 <= '0;
            r_ptr_rs2 <= '0;
            r_ptr_rd  <= '0;
        end else if (load_i) begin
            r_state <= CALC;
            r_ready <= 1'b0;
            r_vs1   <= vs1_i;
            r_vs2   <= vs2_i;
            r_vd    <= vd_i;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b0;
                end
                CALC: begin
                    r_ptr_rs1 <= OFFS_W'(r_vs1) << REG_SHIFT;
                    r_ptr_rs2 <= OFFS_W'(r_vs2) << REG_SHIFT;
                    r_ptr_rd  <= OFFS_W'(r_vd) << REG_SHIFT;
                    r_state   <= READY;
                    r_ready   <= 1'b1;
                end
                READY: begin
                    r_ready <= 1'b1;
                    if (w_sel_rs1) r_ptr_rs1 <= w_ptr_next;
                    if (w_sel_rs2) r_ptr_rs2 <= w_ptr_next;
                    if (w_sel_rd)  r_ptr_rd  <= w_ptr_next;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef VCVE2_AGU_WRAP_CHECK_EN
    localparam logic [OFFS_W-1:0] LAST_WORD = ~OFFS_W'(STEP - 1);

    logic r_err;
    logic w_wrap;

    // An incrementing get from the last word rolls the pointer back to offset 0.
    assign w_wrap = (w_sel_rs1 || w_sel_rs2 || w_sel_rd) && (w_sel_ptr == LAST_WORD);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (load_i) begin
            r_err <= 1'b0;
        end else if (w_wrap) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule
